// File: rtl/toggle_cover_detect.sv
// toggle_cover_detect: per-bit rise/fall detector that feeds toggle-coverage sinks.
// Samples a monitored bus and pulses one point per observed transition. It also
// keeps a sticky covered bitmap, a covered-point count and an all-covered flag.
//
// Build option: define TOGGLE_REPORT_ONCE_EN to pulse each point at most once
// between resets or clears. The bitmap, count and flag are the same in both builds.
//
// Parameters:
//   WIDTH        monitored bus width (2*WIDTH coverage points)
//   CNT_W        width of hit_count
// Ports:
//   clock        sole clock, rising edge
//   reset        synchronous, active-high
//   sig          monitored bus
//   sample_en    sample sig this cycle; history frozen when low
//   clear        synchronous clear of history, bitmap and count
//   valid        registered toggle pulses; bit 2i = rise of sig[i], 2i+1 = fall
//   covered      sticky bitmap of points toggled since reset/clear
//   hit_count    popcount of covered
//   all_covered  high when every point is covered
module toggle_cover_detect #(
    parameter int unsigned WIDTH = 62,
    parameter int unsigned CNT_W = $clog2(2 * WIDTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     sig,
    input  logic                 sample_en,
    input  logic                 clear,
    output logic [2*WIDTH-1:0]   valid,
    output logic [2*WIDTH-1:0]   covered,
    output logic [CNT_W-1:0]     hit_count,
    output logic                 all_covered
);

    localparam int unsigned PTS = 2 * WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   prev_nxt;
    logic [PTS-1:0]     valid_nxt;
    logic [PTS-1:0]     covered_nxt;
    logic [CNT_W-1:0]   hit_count_nxt;
    logic               all_covered_nxt;

    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [PTS-1:0]     toggle;
    logic [PTS-1:0]     new_hits;
    logic [CNT_W-1:0]   new_cnt;

    // Interleaved rise/fall vector and the count of points hit for the first time
    always_comb begin
        rise     = sig & ~prev;
        fall     = ~sig & prev;
        toggle   = '0;
        new_cnt  = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            toggle[2*i]   = rise[i];
            toggle[2*i+1] = fall[i];
        end
        new_hits = toggle & ~covered;
        for (int j = 0; j < int'(PTS); j++) begin
            new_cnt = new_cnt + CNT_W'(new_hits[j]);
        end
    end

    // Next-state and output logic; clear outranks sampling
    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        valid_nxt     = '0;
        covered_nxt   = covered;
        hit_count_nxt = hit_count;

        if (clear) begin
            state_nxt     = IDLE;
            covered_nxt   = '0;
            hit_count_nxt = '0;
        end else if (sample_en) begin
            prev_nxt = sig;
            case (state)
                IDLE: begin
                    // First sample only loads history; nothing to compare against yet
                    state_nxt = RUN;
                end
                RUN: begin
`ifdef TOGGLE_REPORT_ONCE_EN
                    valid_nxt = new_hits;
`else
                    valid_nxt = toggle;
`endif
                    covered_nxt   = covered | toggle;
                    hit_count_nxt = hit_count + new_cnt;
                end
                default: state_nxt = IDLE;
            endcase
        end

        all_covered_nxt = (hit_count_nxt == CNT_W'(PTS));
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            prev        <= '0;
            valid       <= '0;
            covered     <= '0;
            hit_count   <= '0;
            all_covered <= 1'b0;
        end else begin
            state       <= state_nxt;
            prev        <= prev_nxt;
            valid       <= valid_nxt;
            covered     <= covered_nxt;
            hit_count   <= hit_count_nxt;
            all_covered <= all_covered_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_cover_detect.sv
// Directed bench for toggle_cover_detect at WIDTH=4 with hand-computed expectations.
module tb_toggle_cover_detect;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 4;

`ifdef TOGGLE_REPORT_ONCE_EN
    localparam bit ONCE = 1'b1;
`else
    localparam bit ONCE = 1'b0;
`endif

    logic               clock;
    logic               reset;
    logic [WIDTH-1:0]   sig;
    logic               sample_en;
    logic               clear;
    logic [2*WIDTH-1:0] valid;
    logic [2*WIDTH-1:0] covered;
    logic [CNT_W-1:0]   hit_count;
    logic               all_covered;

    int total;
    int bad;

    toggle_cover_detect #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .sig         (sig),
        .sample_en   (sample_en),
        .clear       (clear),
        .valid       (valid),
        .covered     (covered),
        .hit_count   (hit_count),
        .all_covered (all_covered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic step(input logic [3:0] s, input logic en, input logic clr, input logic rst);
        sig       = s;
        sample_en = en;
        clear     = clr;
        reset     = rst;
        @(posedge clock);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [7:0] v, input logic [7:0] c,
                              input logic [3:0] h, input logic a);
        check({tag, ".valid"}, 32'(valid), 32'(v));
        check({tag, ".covered"}, 32'(covered), 32'(c));
        check({tag, ".hit_count"}, 32'(hit_count), 32'(h));
        check({tag, ".all_covered"}, 32'(all_covered), 32'(a));
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        sig       = '0;
        sample_en = 1'b0;
        clear     = 1'b0;
        reset     = 1'b1;

        step(4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b1, 1'b0, 1'b1);
        expect_all("reset", 8'h00, 8'h00, 4'd0, 1'b0);

        // First sample never reports
        step(4'hF, 1'b1, 1'b0, 1'b0);
        expect_all("first_sample", 8'h00, 8'h00, 4'd0, 1'b0);

        // Clear, then arm with prev=0
        step(4'hF, 1'b1, 1'b1, 1'b0);
        expect_all("clear1", 8'h00, 8'h00, 4'd0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("arm0", 8'h00, 8'h00, 4'd0, 1'b0);

        // Toggle then release
        step(4'h5, 1'b1, 1'b0, 1'b0);
        expect_all("rise5", 8'h11, 8'h11, 4'd2, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("fall5", 8'h22, 8'h33, 4'd4, 1'b0);

        // Repeat: filtered only in the report-once build
        step(4'h5, 1'b1, 1'b0, 1'b0);
        expect_all("rep_rise", ONCE ? 8'h00 : 8'h11, 8'h33, 4'd4, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("rep_fall", ONCE ? 8'h00 : 8'h22, 8'h33, 4'd4, 1'b0);

        // Full closure
        step(4'hF, 1'b1, 1'b0, 1'b0);
        expect_all("all_rise", ONCE ? 8'h44 : 8'h55, 8'h77, 4'd6, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("all_fall", ONCE ? 8'h88 : 8'hAA, 8'hFF, 4'd8, 1'b1);

        // Glitch fully inside a disabled window is not reported
        step(4'h3, 1'b0, 1'b0, 1'b0);
        check("glitch_dis.valid", 32'(valid), 32'h0);
        step(4'h0, 1'b0, 1'b0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("glitch_en", 8'h00, 8'hFF, 4'd8, 1'b1);

        // Freeze: change while disabled is reported at the next enabled edge
        step(4'hF, 1'b0, 1'b0, 1'b0);
        check("freeze1.valid", 32'(valid), 32'h0);
        step(4'hF, 1'b0, 1'b0, 1'b0);
        expect_all("freeze2", 8'h00, 8'hFF, 4'd8, 1'b1);
        step(4'hF, 1'b1, 1'b0, 1'b0);
        expect_all("unfreeze", ONCE ? 8'h00 : 8'h55, 8'hFF, 4'd8, 1'b1);

        // Back to prev=0, then clear together with a 0->F change
        step(4'h0, 1'b1, 1'b0, 1'b0);
        check("back0.valid", 32'(valid), ONCE ? 32'h00 : 32'hAA);
        step(4'hF, 1'b1, 1'b1, 1'b0);
        expect_all("clear_mid", 8'h00, 8'h00, 4'd0, 1'b0);
        step(4'hF, 1'b1, 1'b0, 1'b0);
        expect_all("rearm", 8'h00, 8'h00, 4'd0, 1'b0);
        step(4'h0, 1'b1, 1'b0, 1'b0);
        expect_all("after_clear", 8'hAA, 8'hAA, 4'd4, 1'b0);

        // Reset outranks everything
        step(4'hF, 1'b1, 1'b0, 1'b1);
        expect_all("reset_mid", 8'h00, 8'h00, 4'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toggle_cover_detect.md
# toggle_cover_detect

Per-bit toggle detector that sits directly upstream of the toggle-coverage reporting sinks. It samples a monitored bus, detects 0→1 and 1→0 transitions on every bit, and drives a registered one-hot-per-point `valid` vector sized for a coverage sink (two points per monitored bit). It also keeps a sticky covered bitmap, a covered-point count and an all-covered flag for closure tracking.

## Interface
- `WIDTH`, default 62: monitored bus width; the coverage point count is `2*WIDTH`, which is 124 at the default.
- `CNT_W`, default `$clog2(2*WIDTH+1)`: width of `hit_count`.
- `clock` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `sig` in WIDTH: monitored signal bus.
- `sample_en` in 1: sample `sig` this cycle; when low, history is frozen.
- `clear` in 1: synchronous clear of history, covered bitmap and count.
- `valid` out 2*WIDTH: registered toggle pulses; bit `2i` = rise on `sig[i]`, bit `2i+1` = fall on `sig[i]`.
- `covered` out 2*WIDTH: sticky bitmap of points ever toggled since reset or clear.
- `hit_count` out CNT_W: popcount of `covered`.
- `all_covered` out 1: high when `hit_count == 2*WIDTH`.

## Operation
- State:
  - `prev[WIDTH]`: last sampled value.
  - `armed`: history valid.
  - `covered`, `hit_count`, `all_covered`, `valid`: output registers.
- Priority at each edge: `reset` > `clear` > `sample_en` > hold.
- Reset or clear:
  - `valid`, `covered`, `hit_count`, `all_covered` and `armed` all go to 0.
  - `prev` is don't-care.
- Unarmed (IDLE) with `sample_en=1`:
  - `prev <= sig`, `armed <= 1`, `valid <= 0`.
  - The first sample never reports: no toggle is claimed against an unknown history.
- Armed (RUN) with `sample_en=1`:
  - `rise = sig & ~prev`, `fall = ~sig & prev`.
  - `toggle` interleaves them: `toggle[2i] = rise[i]`, `toggle[2i+1] = fall[i]`.
  - `valid <= toggle`, or the filtered form under Configuration.
  - `covered <= covered | toggle`.
  - `hit_count <= hit_count + popcount(toggle & ~covered)`.
  - `prev <= sig`.
- `sample_en=0` in any state: `valid <= 0`; `prev`, `armed`, `covered` and `hit_count` all hold.
- `all_covered <= (next hit_count == 2*WIDTH)`, so it is registered and updates in the same cycle as `hit_count`.
- Arithmetic: `hit_count` cannot exceed `2*WIDTH`; no saturation logic is required. The increment is unsigned and CNT_W wide.
- Two-state machine: IDLE (`armed=0`) → RUN on `sample_en`; RUN → IDLE on `clear` or `reset`.

## Timing
- Latency: a transition present at sampling edge t appears on `valid` during cycle t+1, for exactly one cycle.
- `covered`, `hit_count` and `all_covered` update at the same edge as `valid`.
- A bit that changes while `sample_en=0` is reported at the next enabled edge, compared against the frozen `prev`.
- A multi-cycle glitch that returns to its original value entirely within a disabled window is not reported.
- `clear` asserted in the same cycle as a toggle: the toggle is discarded and the next enabled cycle re-arms.
- No backpressure: downstream consumes `valid` unconditionally every cycle.

## Configuration
- `TOGGLE_REPORT_ONCE_EN` defined:
  - `valid <= toggle & ~covered`.
  - Each point pulses at most once between resets or clears, limiting coverage-callback traffic.
- Not defined:
  - `valid <= toggle`; every observed toggle pulses.
  - `covered`, `hit_count` and `all_covered` behave identically in both builds.

## Test plan
All scenarios use WIDTH=4.

- First sample suppression: reset, then `sample_en=1` with `sig=4'hF` → `valid=0` next cycle, `hit_count=0`.
- Toggle then release:
  - Starting from armed `prev=4'h0`, drive `sig=4'h5` → next cycle `valid=8'h11`, `hit_count=2`.
  - Then drive `sig=4'h0` → `valid=8'h22`, `hit_count=4`.
- Repeat filtering: repeat 0→5→0.
  - Without `TOGGLE_REPORT_ONCE_EN`: `valid` shows `8'h11` then `8'h22` again.
  - With it: `valid=0` on the repeat.
  - `hit_count` stays 4 in both builds.
- Full closure: toggle all bits, 0→F→0 → `hit_count=8`, `all_covered=1` in the cycle `valid=8'hAA` appears.
- Freeze: with `prev=0`, hold `sample_en=0` while `sig` goes 0→F, then assert `sample_en` → `valid=8'h55` one cycle after enable.
- Clear mid-run: assert `clear` together with a 0→F change → `valid=0`, `covered=0`, `hit_count=0`; the next enabled sample only re-arms and produces no pulse.
